// File: rtl/regseq_pkg.sv
// Shared types and default sizes for the register-transfer sequencer.
// The sequencer and its testbench both import this package.
package regseq_pkg;

   localparam int DEF_WIDTH       = 10;
   localparam int DEF_NREG        = 4;
   localparam int DEF_ALU_TIMEOUT = 15;

   typedef enum logic [1:0] {
      OP_LOADI = 2'b00,
      OP_MOV   = 2'b01,
      OP_ALU   = 2'b10,
      OP_OUT   = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_EXEC  = 3'd2,
      S_WRITE = 3'd3,
      S_EMIT  = 3'd4
   } state_t;

endpackage

// File: rtl/alu_watchdog.sv
// Down-counter bounding how long EXEC waits for the external ALU.
// Loaded on EXEC entry; expired_o flags the last allowed cycle with no alu_done.
module alu_watchdog #(
   parameter int TIMEOUT = 15
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic run_i,
   input  logic alu_done_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT + 1);
   // Loading TIMEOUT-1 makes the count hit zero in EXEC cycle number TIMEOUT.
   localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] ZERO     = {CW{1'b0}};

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: reload, decrement while running, otherwise hold.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (run_i && (cnt_q != ZERO)) begin
         cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= ZERO;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = run_i && (cnt_q == ZERO) && !alu_done_i;

endmodule

// File: rtl/regfile_sequencer.sv
// Single owner of the register file control ports: runs one LOADI/MOV/ALU/OUT
// operation at a time, driving reads, the external ALU handshake and the write.
module regfile_sequencer
   import regseq_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int NREG        = DEF_NREG,
   parameter int ALU_TIMEOUT = DEF_ALU_TIMEOUT
) (
   input  logic                     CLKb,
   input  logic                     RST,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [1:0]               req_op,
   input  logic [$clog2(NREG)-1:0]  req_rd,
   input  logic [$clog2(NREG)-1:0]  req_ra,
   input  logic [$clog2(NREG)-1:0]  req_rb,
   input  logic [WIDTH-1:0]         req_imm,
   output logic                     ENW,
   output logic                     ENR0,
   output logic                     ENR1,
   output logic [$clog2(NREG)-1:0]  WRA,
   output logic [$clog2(NREG)-1:0]  RDA0,
   output logic [$clog2(NREG)-1:0]  RDA1,
   output logic [WIDTH-1:0]         D,
   input  logic [WIDTH-1:0]         Q0,
   input  logic [WIDTH-1:0]         Q1,
   output logic [WIDTH-1:0]         alu_a,
   output logic [WIDTH-1:0]         alu_b,
   output logic                     alu_start,
   input  logic                     alu_done,
   input  logic [WIDTH-1:0]         alu_result,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   output logic                     done,
   output logic                     err
);

   localparam int AW = $clog2(NREG);

   state_t           state_q,    state_d;
   op_t              op_q,       op_d;
   logic [AW-1:0]    rd_q,       rd_d;
   logic [AW-1:0]    ra_q,       ra_d;
   logic [AW-1:0]    rb_q,       rb_d;
   logic [WIDTH-1:0] d_q,        d_d;
   logic [WIDTH-1:0] alu_a_q,    alu_a_d;
   logic [WIDTH-1:0] alu_b_q,    alu_b_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             start_q,    start_d;
   logic             wd_expired_s;
   logic             wd_load_s;

   assign wd_load_s = (state_q == S_READ) && (op_q == OP_ALU);

   alu_watchdog #(
      .TIMEOUT (ALU_TIMEOUT)
   ) u_watchdog (
      .clk_i      (CLKb),
      .rst_i      (RST),
      .load_i     (wd_load_s),
      .run_i      (state_q == S_EXEC),
      .alu_done_i (alu_done),
      .expired_o  (wd_expired_s)
   );

   // Next-state and datapath capture for the operation sequence.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      rd_d       = rd_q;
      ra_d       = ra_q;
      rb_d       = rb_q;
      d_d        = d_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      out_data_d = out_data_q;
      start_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d = op_t'(req_op);
               rd_d = req_rd;
               ra_d = req_ra;
               rb_d = req_rb;
               if (op_t'(req_op) == OP_LOADI) begin
                  d_d     = req_imm;
                  state_d = S_WRITE;
               end else begin
                  state_d = S_READ;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ: begin
            alu_a_d = Q0;
            case (op_q)
               OP_ALU: begin
                  alu_b_d = Q1;
                  start_d = 1'b1;
                  state_d = S_EXEC;
               end
               OP_MOV: begin
                  d_d     = Q0;
                  state_d = S_WRITE;
               end
               OP_OUT: begin
                  // Loaded here so out_data is already valid alongside out_valid.
                  out_data_d = Q0;
                  state_d    = S_EMIT;
               end
               default: state_d = S_IDLE;
            endcase
         end
         S_EXEC: begin
            if (alu_done) begin
               d_d     = alu_result;
               state_d = S_WRITE;
            end else if (wd_expired_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_WRITE: state_d = S_IDLE;
         S_EMIT:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Sequencer state and latched operation fields.
   always_ff @(posedge CLKb) begin
      if (RST) begin
         state_q    <= S_IDLE;
         op_q       <= OP_LOADI;
         rd_q       <= {AW{1'b0}};
         ra_q       <= {AW{1'b0}};
         rb_q       <= {AW{1'b0}};
         d_q        <= {WIDTH{1'b0}};
         alu_a_q    <= {WIDTH{1'b0}};
         alu_b_q    <= {WIDTH{1'b0}};
         out_data_q <= {WIDTH{1'b0}};
         start_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         rd_q       <= rd_d;
         ra_q       <= ra_d;
         rb_q       <= rb_d;
         d_q        <= d_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         out_data_q <= out_data_d;
         start_q    <= start_d;
      end
   end

   // Enables and pulses are gated by RST so a reset cycle never writes.
   assign req_ready = (state_q == S_IDLE) && !RST;
   assign ENR0      = (state_q == S_READ) && !RST;
   assign ENR1      = (state_q == S_READ) && (op_q == OP_ALU) && !RST;
   assign ENW       = (state_q == S_WRITE) && !RST;
   assign done      = ((state_q == S_WRITE) || (state_q == S_EMIT)) && !RST;
   assign out_valid = (state_q == S_EMIT) && !RST;
   assign alu_start = start_q && !RST;
   assign err       = wd_expired_s && !RST;

   assign WRA      = rd_q;
   assign RDA0     = ra_q;
   assign RDA1     = rb_q;
   assign D        = d_q;
   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign out_data = out_data_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 4 x 10-bit register
// file that captures on the falling clock edge during ENW.
module tb_regfile_sequencer;

   logic       CLKb = 1'b0;
   logic       RST;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [1:0] req_rd, req_ra, req_rb;
   logic [9:0] req_imm;
   logic       ENW, ENR0, ENR1;
   logic [1:0] WRA, RDA0, RDA1;
   logic [9:0] D, Q0, Q1;
   logic [9:0] alu_a, alu_b;
   logic       alu_start;
   logic       alu_done;
   logic [9:0] alu_result;
   logic [9:0] out_data;
   logic       out_valid;
   logic       done;
   logic       err;

   logic [9:0] rf [4];
   int n_total = 0;
   int n_pass  = 0;
   int start_cnt = 0;
   int err_cnt   = 0;
   int base;

   regfile_sequencer dut (
      .CLKb(CLKb), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_rd(req_rd), .req_ra(req_ra), .req_rb(req_rb),
      .req_imm(req_imm), .ENW(ENW), .ENR0(ENR0), .ENR1(ENR1), .WRA(WRA),
      .RDA0(RDA0), .RDA1(RDA1), .D(D), .Q0(Q0), .Q1(Q1), .alu_a(alu_a),
      .alu_b(alu_b), .alu_start(alu_start), .alu_done(alu_done),
      .alu_result(alu_result), .out_data(out_data), .out_valid(out_valid),
      .done(done), .err(err)
   );

   always #5 CLKb = ~CLKb;

   initial begin
      for (int i = 0; i < 4; i++) rf[i] = 10'h000;
   end

   always @(negedge CLKb) begin
      if (ENW === 1'b1) rf[WRA] <= D;
   end

   assign Q0 = (ENR0 === 1'b1) ? rf[RDA0] : 10'h000;
   assign Q1 = (ENR1 === 1'b1) ? rf[RDA1] : 10'h000;

   always @(posedge CLKb) begin
      if (alu_start === 1'b1) start_cnt++;
      if (err === 1'b1) err_cnt++;
   end

   task automatic tick();
      @(posedge CLKb);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic offer(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] ra,
                        input logic [1:0] rb, input logic [9:0] imm);
      req_valid = 1'b1; req_op = op; req_rd = rd; req_ra = ra; req_rb = rb; req_imm = imm;
      #1;
      check("accept_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      #1;
   endtask

   initial begin
      RST = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_rd = 2'd0; req_ra = 2'd0;
      req_rb = 2'd0; req_imm = 10'h000; alu_done = 1'b0; alu_result = 10'h000;
      tick(); tick();
      check("rst_ready", req_ready, 0);
      check("rst_enw", ENW, 0);
      check("rst_enr0", ENR0, 0);
      check("rst_wra", WRA, 0);
      check("rst_d", D, 0);
      check("rst_out_data", out_data, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      RST = 1'b0;
      #1;

      // LOADI R2 = 0x2A5
      offer(2'b00, 2'd2, 2'd0, 2'd0, 10'h2A5);
      check("loadi_enw", ENW, 1);
      check("loadi_wra", WRA, 2);
      check("loadi_d", D, 10'h2A5);
      check("loadi_done", done, 1);
      check("loadi_ready", req_ready, 0);
      tick();
      check("loadi_r2", rf[2], 10'h2A5);
      check("loadi_done_clr", done, 0);

      // MOV R3 = R2
      offer(2'b01, 2'd3, 2'd2, 2'd0, 10'h000);
      check("mov_enr0", ENR0, 1);
      check("mov_rda0", RDA0, 2);
      check("mov_enr1_rd", ENR1, 0);
      check("mov_enw_rd", ENW, 0);
      tick();
      check("mov_enw", ENW, 1);
      check("mov_wra", WRA, 3);
      check("mov_d", D, 10'h2A5);
      check("mov_enr1_wr", ENR1, 0);
      check("mov_done", done, 1);
      tick();
      check("mov_r3", rf[3], 10'h2A5);

      // ALU R1 = f(R2, R3), alu_done in the 4th EXEC cycle
      base = start_cnt;
      offer(2'b10, 2'd1, 2'd2, 2'd3, 10'h000);
      check("alu_enr0", ENR0, 1);
      check("alu_enr1", ENR1, 1);
      check("alu_rda1", RDA1, 3);
      check("alu_start_rd", alu_start, 0);
      tick();
      check("alu_start_1", alu_start, 1);
      check("alu_a", alu_a, 10'h2A5);
      check("alu_b", alu_b, 10'h2A5);
      tick();
      check("alu_start_2", alu_start, 0);
      tick();
      tick();
      alu_done = 1'b1; alu_result = 10'h14A;
      #1;
      check("alu_done_cyc_no_done", done, 0);
      tick();
      alu_done = 1'b0; alu_result = 10'h000;
      #1;
      check("alu_enw", ENW, 1);
      check("alu_wra", WRA, 1);
      check("alu_d", D, 10'h14A);
      check("alu_done", done, 1);
      check("alu_start_count", start_cnt - base, 1);
      tick();
      check("alu_r1", rf[1], 10'h14A);

      // ALU timeout: no alu_done for 15 EXEC cycles
      base = err_cnt;
      offer(2'b10, 2'd0, 2'd1, 2'd1, 10'h000);
      tick();
      for (int i = 1; i < 15; i++) begin
         check("to_no_err_early", err, 0);
         tick();
      end
      check("to_err", err, 1);
      check("to_no_enw", ENW, 0);
      check("to_no_done", done, 0);
      tick();
      check("to_ready_after", req_ready, 1);
      check("to_err_clr", err, 0);
      check("to_err_count", err_cnt - base, 1);
      check("to_r0_untouched", rf[0], 10'h000);

      // alu_done in the last allowed EXEC cycle wins
      offer(2'b10, 2'd2, 2'd1, 2'd1, 10'h000);
      tick();
      for (int i = 1; i < 15; i++) tick();
      alu_done = 1'b1; alu_result = 10'h3C3;
      #1;
      check("last_no_err", err, 0);
      tick();
      alu_done = 1'b0;
      #1;
      check("last_enw", ENW, 1);
      check("last_wra", WRA, 2);
      check("last_d", D, 10'h3C3);
      tick();
      check("last_r2", rf[2], 10'h3C3);

      // OUT R1
      offer(2'b11, 2'd0, 2'd1, 2'd0, 10'h000);
      check("out_enr0", ENR0, 1);
      check("out_rda0", RDA0, 1);
      tick();
      check("out_valid", out_valid, 1);
      check("out_data", out_data, 10'h14A);
      check("out_done", done, 1);
      check("out_no_enw", ENW, 0);
      tick();
      check("out_valid_clr", out_valid, 0);
      check("out_data_hold", out_data, 10'h14A);
      check("out_ready", req_ready, 1);

      // Back-to-back LOADIs with req_valid held high
      req_valid = 1'b1; req_op = 2'b00; req_rd = 2'd3;
      for (int i = 0; i < 6; i++) begin
         req_imm = 10'h100 + 10'(i);
         #1;
         check("b2b_ready", req_ready, (i % 2 == 0) ? 1 : 0);
         if (i % 2 == 1) check("b2b_d", D, 10'h100 + 10'(i - 1));
         tick();
      end
      req_valid = 1'b0;
      #1;
      check("b2b_r3", rf[3], 10'h104);

      // Reset in the WRITE cycle of LOADI R0
      offer(2'b00, 2'd0, 2'd0, 2'd0, 10'h155);
      RST = 1'b1;
      #1;
      check("rstw_enw", ENW, 0);
      check("rstw_done", done, 0);
      tick();
      RST = 1'b0;
      #1;
      check("rstw_idle", req_ready, 1);
      check("rstw_r0", rf[0], 10'h000);
      check("rstw_no_done", done, 0);
      check("rstw_d_cleared", D, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
